fpu_xif_issue_ctrl: RTL and testbench
=====================================

# fpu_xif_issue_ctrl

In-order issue/commit scheduler between the CORE-V-XIF coprocessor interface and the FPU execute pipeline of rvfpm. It completes issue handshakes using the predecoder's accept decision, buffers accepted instructions in a DEPTH-entry FIFO until the core commits or kills them, and dispatches committed instructions to the pipeline strictly in program order. Pipeline results are registered and returned to the core through a one-entry result buffer.

## Interface
- X_ID_WIDTH, 4: instruction ID width.
- XLEN, 32: result data width.
- DEPTH, 4: outstanding-instruction FIFO depth; power of two, ≥2.
- ck  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  core presents an instruction.
- issue_ready  out  1  scheduler can take a transaction.
- issue_instr  in  32  instruction word.
- issue_id  in  X_ID_WIDTH  instruction ID.
- dec_accept  in  1  combinational predecoder accept for issue_instr.
- issue_accept  out  1  equals dec_accept during a handshake, else 0.
- commit_valid  in  1  commit strobe.
- commit_id  in  X_ID_WIDTH  ID being committed.
- commit_kill  in  1  1 = discard the instruction.
- exec_valid  out  1  head instruction offered to the pipeline.
- exec_ready  in  1  pipeline takes it.
- exec_instr  out  32  head instruction.
- exec_id  out  X_ID_WIDTH  head ID.
- res_valid_in  in  1  pipeline result valid.
- res_ready_in  out  1  scheduler can take a result.
- res_id_in  in  X_ID_WIDTH  result ID.
- res_data_in  in  XLEN  result data.
- result_valid  out  1  result to core.
- result_ready  in  1  core takes the result.
- result_id  out  X_ID_WIDTH  registered ID.
- result_data  out  XLEN  registered data.
- in_flight  out  $clog2(DEPTH+1)  occupied FIFO entries.
- commit_err  out  1  sticky: a commit matched no pending entry.

## Operation
- Each FIFO entry holds {instr, id, committed, killed}. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- issue_ready = (in_flight != DEPTH). A full FIFO holds issue_ready low, even when a pop occurs in the same cycle.
- Handshake is issue_valid && issue_ready. If dec_accept = 1, the instruction is pushed with committed = killed = 0. If dec_accept = 0, the transaction completes as rejected and nothing is stored.
- Commit searches all valid entries whose id == commit_id and whose committed bit is 0. The oldest match gets committed = 1 and killed = commit_kill.
- A commit in the same cycle as the push of the same ID applies to the new entry.
- A commit that matches no entry, or a repeated commit, is ignored and sets commit_err. commit_err clears only on reset.
- Head entry handling:
  - Uncommitted: wait.
  - Committed and not killed: exec_valid = 1. The entry pops on exec_valid && exec_ready.
  - Killed: popped internally, one entry per cycle, with exec_valid = 0.
- exec_instr and exec_id come directly from head storage, so they are stable while exec_valid is held.
- Result buffer:
  - res_ready_in = !result_valid || result_ready.
  - On res_valid_in && res_ready_in, the buffer loads id and data and sets result_valid.
  - On result_valid && result_ready with no new load, result_valid clears.
  - Load and drain in the same cycle replaces the contents and keeps result_valid = 1.
- in_flight increments on push, decrements on pop, and is unchanged when both happen in one cycle.

## Timing
- Reset (rst_n low, asynchronous) clears pointers, in_flight, all entry flags, result_valid and commit_err.
- Reset values: issue_ready = 1, exec_valid = 0, result_valid = 0, result_id = 0, result_data = 0, in_flight = 0, commit_err = 0.
- Reset in mid-operation discards all outstanding entries and any held result.
- issue_accept, issue_ready and res_ready_in are combinational and carry no state.
- Best-case latency: push and commit in cycle N gives exec_valid in cycle N+1.
- A commit arriving in cycle M for an entry already at the head gives exec_valid in cycle M+1.
- Result latency: res_valid_in accepted in cycle N gives result_valid in cycle N+1.
- A stalled result holds id and data stable until result_ready.
- exec_valid is never withdrawn before exec_ready.
- Killed-head pop takes one cycle per entry, and dispatch of the next head resumes the following cycle.

## Test plan
- Reset, then issue id=3 with dec_accept=1 and commit id=3 with kill=0 in the same cycle → exec_valid=1 with exec_id=3 next cycle; pop on exec_ready; in_flight returns to 0.
- Issue ids 1,2,3,4 (DEPTH=4) with no commits → issue_ready=0 at in_flight=4; commit id=1 with exec_ready=1 → one pop; issue_ready=1 the cycle after.
- Issue ids 5,6 and commit 5 with kill=1, then 6 with kill=0 → id 5 never appears on exec; exec_id=6 appears one cycle after the kill pop.
- Issue with dec_accept=0 → issue_accept=0, in_flight stays 0, exec_valid stays 0.
- Commit id=9 with an empty FIFO → commit_err=1 and it persists; rst_n pulse clears it.
- Result id=2 with data=0x3F800000 while result_ready=0 → held stable and res_ready_in=0; raise result_ready together with a new res_valid_in (id=7) → result_id=7 next cycle and result_valid stays 1.

Source files
------------

// File: rtl/fpu_xif_issue_ctrl.sv
// In-order issue/commit scheduler between the XIF coprocessor port and the FPU pipeline.
// Accepted instructions wait in a small FIFO until committed or killed; results return through a one-entry buffer.
module fpu_xif_issue_ctrl #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          ck,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [31:0]                   issue_instr,
    input  logic [X_ID_WIDTH-1:0]         issue_id,
    input  logic                          dec_accept,
    output logic                          issue_accept,
    input  logic                          commit_valid,
    input  logic [X_ID_WIDTH-1:0]         commit_id,
    input  logic                          commit_kill,
    output logic                          exec_valid,
    input  logic                          exec_ready,
    output logic [31:0]                   exec_instr,
    output logic [X_ID_WIDTH-1:0]         exec_id,
    input  logic                          res_valid_in,
    output logic                          res_ready_in,
    input  logic [X_ID_WIDTH-1:0]         res_id_in,
    input  logic [XLEN-1:0]               res_data_in,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [X_ID_WIDTH-1:0]         result_id,
    output logic [XLEN-1:0]               result_data,
    output logic [$clog2(DEPTH+1)-1:0]    in_flight,
    output logic                          commit_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]            instr_q [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [DEPTH-1:0]       vld_q, vld_d, cmt_q, cmt_d, kill_q, kill_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   rv_q, rv_d;
    logic [X_ID_WIDTH-1:0]  rid_q, rid_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;

    logic                   push, pop, kill_pop, match_found, new_cmt;
    logic [PTR_W-1:0]       match_idx, idx;

    assign issue_ready  = (cnt_q != CNT_W'(DEPTH));
    assign issue_accept = issue_valid && issue_ready && dec_accept;
    assign push         = issue_accept;

    assign exec_valid = vld_q[head_q] && cmt_q[head_q] && !kill_q[head_q];
    assign exec_instr = instr_q[head_q];
    assign exec_id    = id_q[head_q];
    assign kill_pop   = vld_q[head_q] && cmt_q[head_q] && kill_q[head_q];
    assign pop        = kill_pop || (exec_valid && exec_ready);

    // Valid entries are contiguous from head, so scanning from head finds the oldest match first.
    always_comb begin
        match_found = 1'b0;
        match_idx   = head_q;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (!match_found && vld_q[idx] && !cmt_q[idx] && (id_q[idx] == commit_id)) begin
                match_found = 1'b1;
                match_idx   = idx;
            end
        end
    end

    always_comb begin
        vld_d   = vld_q;
        cmt_d   = cmt_q;
        kill_d  = kill_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        new_cmt = 1'b0;
        if (commit_valid) begin
            if (match_found) begin
                cmt_d[match_idx]  = 1'b1;
                kill_d[match_idx] = commit_kill;
            end else if (push && (issue_id == commit_id)) begin
                new_cmt = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            vld_d[head_q]  = 1'b0;
            cmt_d[head_q]  = 1'b0;
            kill_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[tail_q]  = 1'b1;
            cmt_d[tail_q]  = new_cmt;
            kill_d[tail_q] = new_cmt && commit_kill;
            tail_d         = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign res_ready_in = !rv_q || result_ready;

    always_comb begin
        rv_d    = rv_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        if (res_valid_in && res_ready_in) begin
            rv_d    = 1'b1;
            rid_d   = res_id_in;
            rdata_d = res_data_in;
        end else if (result_ready) begin
            rv_d = 1'b0;
        end
    end

    // Payload storage carries no reset; the per-entry valid bits gate its use.
    always_ff @(posedge ck) begin
        if (push) begin
            instr_q[tail_q] <= issue_instr;
            id_q[tail_q]    <= issue_id;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rdata_q <= '0;
        end else begin
            vld_q   <= vld_d;
            cmt_q   <= cmt_d;
            kill_q  <= kill_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
        end
    end

    assign result_valid = rv_q;
    assign result_id    = rid_q;
    assign result_data  = rdata_q;
    assign in_flight    = cnt_q;
    assign commit_err   = err_q;

endmodule

// File: tb/tb_fpu_xif_issue_ctrl.sv
// Bench for fpu_xif_issue_ctrl: a queue-based reference model predicts each cycle's outputs,
// and a separate monitor compares the DUT against those predictions and the result scoreboard.
module tb_fpu_xif_issue_ctrl;
    localparam int DEPTH = 4;

    logic        ck = 1'b0;
    logic        rst_n = 1'b1;
    logic        issue_valid = 0, dec_accept = 0, commit_valid = 0, commit_kill = 0;
    logic        exec_ready = 0, res_valid_in = 0, result_ready = 0;
    logic [31:0] issue_instr = '0, res_data_in = '0;
    logic [3:0]  issue_id = '0, commit_id = '0, res_id_in = '0;
    logic        issue_ready, issue_accept, exec_valid, res_ready_in, result_valid, commit_err;
    logic [31:0] exec_instr, result_data;
    logic [3:0]  exec_id, result_id;
    logic [2:0]  in_flight;

    always #5 ck = ~ck;

    fpu_xif_issue_ctrl #(.X_ID_WIDTH(4), .XLEN(32), .DEPTH(DEPTH)) dut (
        .ck(ck), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_id(issue_id), .dec_accept(dec_accept), .issue_accept(issue_accept),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_instr(exec_instr), .exec_id(exec_id),
        .res_valid_in(res_valid_in), .res_ready_in(res_ready_in), .res_id_in(res_id_in),
        .res_data_in(res_data_in), .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data), .in_flight(in_flight),
        .commit_err(commit_err)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  id;
        logic        cmt;
        logic        kill;
    } ent_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } res_t;

    ent_t mq[$];
    res_t rq[$];
    logic m_err = 1'b0;
    logic mdl_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic        exp_issue_ready, exp_issue_accept, exp_exec_valid, exp_commit_err;
    logic        exp_result_valid, exp_res_ready;
    logic [3:0]  exp_exec_id;
    logic [31:0] exp_exec_instr;
    int          exp_in_flight;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: predict this cycle's outputs, then apply this cycle's transactions.
    task automatic model_update();
        logic pop, push;
        int   sel;
        ent_t e;
        ent_t t;
        #1;
        exp_issue_ready  = (mq.size() != DEPTH);
        exp_issue_accept = issue_valid && exp_issue_ready && dec_accept;
        exp_in_flight    = mq.size();
        exp_exec_valid   = (mq.size() > 0) && mq[0].cmt && !mq[0].kill;
        if (exp_exec_valid) begin
            exp_exec_id    = mq[0].id;
            exp_exec_instr = mq[0].instr;
        end
        exp_commit_err   = m_err;
        exp_result_valid = (rq.size() != 0);
        exp_res_ready    = !exp_result_valid || result_ready;

        pop  = (mq.size() > 0) && mq[0].cmt && (mq[0].kill || exec_ready);
        push = exp_issue_accept;
        sel  = -1;
        if (commit_valid) begin
            for (int i = 0; i < mq.size(); i++)
                if (sel < 0 && !mq[i].cmt && mq[i].id == commit_id) sel = i;
            if (sel >= 0) begin
                t = mq[sel];
                t.cmt = 1'b1;
                t.kill = commit_kill;
                mq[sel] = t;
            end else if (!(push && issue_id == commit_id)) begin
                m_err = 1'b1;
            end
        end
        e.instr = issue_instr;
        e.id    = issue_id;
        e.cmt   = commit_valid && (sel < 0) && (issue_id == commit_id);
        e.kill  = e.cmt && commit_kill;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (res_valid_in && exp_res_ready) rq.push_back({res_id_in, res_data_in});
    endtask

    task automatic cyc(input logic iv, input logic [3:0] iid, input logic acc,
                       input logic cv, input logic [3:0] cid, input logic kl, input logic er,
                       input logic rv, input logic [3:0] rid, input logic [31:0] rd, input logic rr);
        @(negedge ck);
        mdl_en       = 1'b1;
        issue_valid  = iv;
        issue_id     = iid;
        issue_instr  = 32'hF000_0000 ^ {iid, 4'h0, 8'hA5, iid, 12'h3C1};
        dec_accept   = acc;
        commit_valid = cv;
        commit_id    = cid;
        commit_kill  = kl;
        exec_ready   = er;
        res_valid_in = rv;
        res_id_in    = rid;
        res_data_in  = rd;
        result_ready = rr;
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge ck);
        mdl_en = 1'b0;
        issue_valid = 0; commit_valid = 0; exec_ready = 0; res_valid_in = 0; result_ready = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_exec_valid", 32'(exec_valid), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_id", 32'(result_id), 32'd0);
        chk("rst_result_data", result_data, 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_commit_err", 32'(commit_err), 32'd0);
        mq.delete();
        rq.delete();
        m_err = 1'b0;
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs with the model's predictions and drains the result scoreboard.
    always @(negedge ck) begin
        #2;
        if (mdl_en) begin
            chk("issue_ready", 32'(issue_ready), 32'(exp_issue_ready));
            chk("issue_accept", 32'(issue_accept), 32'(exp_issue_accept));
            chk("in_flight", 32'(in_flight), exp_in_flight);
            chk("commit_err", 32'(commit_err), 32'(exp_commit_err));
            chk("exec_valid", 32'(exec_valid), 32'(exp_exec_valid));
            if (exp_exec_valid) begin
                chk("exec_id", 32'(exec_id), 32'(exp_exec_id));
                chk("exec_instr", exec_instr, exp_exec_instr);
            end
            chk("res_ready_in", 32'(res_ready_in), 32'(exp_res_ready));
            chk("result_valid", 32'(result_valid), 32'(exp_result_valid));
            if (exp_result_valid) begin
                chk("result_id", 32'(result_id), 32'(rq[0].id));
                chk("result_data", result_data, rq[0].data);
                if (result_ready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        apply_reset();

        // Issue and commit id 3 together, dispatch next cycle.
        cyc(1, 4'd3, 1, 1, 4'd3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Fill the FIFO, try to overfill, then commit the head.
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4'd1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        for (int i = 2; i <= 4; i++) cyc(0, 0, 0, 1, 4'(i), 1, 0, 0, 0, 0, 0);
        idle(3);

        // Killed head is skipped, survivor follows.
        cyc(1, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4'd6, 1, 1, 4'd5, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4'd6, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Rejected issue stores nothing.
        cyc(1, 4'd8, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Orphan commit sets the sticky error; reset clears it.
        cyc(0, 0, 0, 1, 4'd9, 0, 0, 0, 0, 0, 0);
        idle(3);
        apply_reset();

        // Result buffer stall, then replace-on-drain.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 32'h3F80_0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4'd4, 32'h1111_2222, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 32'h4000_0000, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Randomised traffic with a mid-run reset.
        for (int n = 0; n < 2000; n++) begin
            logic        iv, acc, cv, kl, er, rv, rr;
            logic [3:0]  iid, cid, rid;
            logic [31:0] rd;
            int          r;
            int          cands[$];
            iv  = ($urandom_range(0, 99) < 50);
            iid = 4'($urandom);
            acc = ($urandom_range(0, 9) < 8);
            cv  = ($urandom_range(0, 99) < 45);
            kl  = ($urandom_range(0, 9) < 3);
            er  = ($urandom_range(0, 99) < 60);
            rv  = ($urandom_range(0, 99) < 50);
            rid = 4'($urandom);
            rd  = $urandom;
            rr  = ($urandom_range(0, 99) < 50);
            foreach (mq[i]) if (!mq[i].cmt) cands.push_back(int'(mq[i].id));
            r = $urandom_range(0, 19);
            if (r < 15 && cands.size() > 0) cid = 4'(cands[$urandom_range(0, cands.size() - 1)]);
            else if (r < 19) cid = iid;
            else cid = 4'($urandom);
            cyc(iv, iid, acc, cv, cid, kl, er, rv, rid, rd, rr);
            if (n == 1000) apply_reset();
        end
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
